msdap_out_tx: RTL

MSDAP_OUT_TX -- requirements
Module: msdap_out_tx

---
 rtl/msdap_out_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/msdap_out_tx.sv
// MSDAP serial output transmitter: one-pair holding buffer feeding two MSB-first shift registers.
// Optional MSDAP_OUT_TX_UNDERRUN_EN: a Frame with an empty buffer sends a zero word and sets underrun.
module msdap_out_tx #(
  parameter int WIDTH = 40
) (
  input  logic             Sclk,
  input  logic             Reset,
  input  logic             Frame,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] DataL,
  input  logic [WIDTH-1:0] DataR,
  output logic             OutputL,
  output logic             OutputR,
  output logic             OutReady,
  output logic             underrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             buf_full_q;
  logic [WIDTH-1:0] buf_l_q, buf_r_q;
  logic [WIDTH-1:0] sh_l_q, sh_r_q;
  logic             out_l_q, out_r_q, out_rdy_q;
  logic             capture, start;
  logic [WIDTH-1:0] word_l, word_r;

  assign in_ready = !buf_full_q;
  assign capture  = in_valid && !buf_full_q;

`ifdef MSDAP_OUT_TX_UNDERRUN_EN
  logic underrun_q;
  // An empty buffer still starts a word, but the word is forced to zero.
  assign start    = Frame && (state_q == IDLE);
  assign word_l   = buf_full_q ? buf_l_q : '0;
  assign word_r   = buf_full_q ? buf_r_q : '0;
  assign underrun = underrun_q;
`else
  assign start    = Frame && (state_q == IDLE) && buf_full_q;
  assign word_l   = buf_l_q;
  assign word_r   = buf_r_q;
  assign underrun = 1'b0;
`endif

  assign OutputL  = out_l_q;
  assign OutputR  = out_r_q;
  assign OutReady = out_rdy_q;

  // NOTE: all state here is sequential, so every assignment uses <= to keep
  // the update order-independent across the block.
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      // NOTE: buffer and shift registers are cleared too, so a reset leaves no
      // stale word that a later Frame could send.
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      out_l_q    <= 1'b0;
      out_r_q    <= 1'b0;
      out_rdy_q  <= 1'b0;
`ifdef MSDAP_OUT_TX_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      // Start sees the pre-edge buffer, so a pair captured this cycle is never bypassed.
      if (start) buf_full_q <= 1'b0;
      if (capture) begin
        buf_l_q    <= DataL;
        buf_r_q    <= DataR;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            cnt_q     <= '0;
            out_l_q   <= word_l[WIDTH-1];
            out_r_q   <= word_r[WIDTH-1];
            out_rdy_q <= 1'b1;
            sh_l_q    <= {word_l[WIDTH-2:0], 1'b0};
            sh_r_q    <= {word_r[WIDTH-2:0], 1'b0};
`ifdef MSDAP_OUT_TX_UNDERRUN_EN
            if (!buf_full_q) underrun_q <= 1'b1;
`endif
          end
        end
        SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_l_q   <= 1'b0;
            out_r_q   <= 1'b0;
            out_rdy_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            out_l_q <= sh_l_q[WIDTH-1];
            out_r_q <= sh_r_q[WIDTH-1];
            sh_l_q  <= {sh_l_q[WIDTH-2:0], 1'b0};
            sh_r_q  <= {sh_r_q[WIDTH-2:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
